mem_ctrl: RTL

- Responder end of the cache-to-memory busy/done handshake.
- Serves the instruction cache (read-only port) and the data cache (read/write port with byte mask).
- Serializes each 32-bit word request into four byte accesses on a byte-wide synchronous RAM (1-cycle read latency).
- Sits between the CPU top's external memory ports and the RAM.

---
 rtl/mem_ctrl_pkg.sv | 27 ++
 rtl/mem_ctrl_if.sv | 42 ++++
 rtl/mem_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the cache-to-RAM byte-serialising memory controller.
package mem_ctrl_pkg;

    localparam int unsigned AddrWDefault = 17;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    typedef enum logic {
        PortInst,
        PortData
    } port_e;

    // Last counter value of each sequence (READ needs one extra cycle for RAM latency)
    localparam logic [2:0] ReadLastCnt  = 3'd4;
    localparam logic [2:0] WriteLastCnt = 3'd3;

    // Little-endian byte select: idx 0 is word[7:0]
    function automatic logic [7:0] get_byte(input logic [31:0] word, input logic [1:0] idx);
        return word[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the instruction/data cache handshakes and the byte-wide RAM port.
interface mem_ctrl_if #(
    parameter int unsigned ADDR_W = 17
);
    // Instruction cache port
    logic              inst_read_i;
    logic [31:0]       inst_addr_i;
    logic [31:0]       inst_data_o;
    logic              inst_busy_o;
    logic              inst_done_o;
    // Data cache port
    logic              data_read_i;
    logic              data_write_i;
    logic [31:0]       data_addr_i;
    logic [31:0]       data_data_i;
    logic [3:0]        data_mask_i;
    logic [31:0]       data_data_o;
    logic              data_busy_o;
    logic              data_done_o;
    // Byte RAM port
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_dout_o;
    logic              ram_we_o;
    logic [7:0]        ram_din_i;

    // Controller side
    modport slave (
        input  inst_read_i, inst_addr_i, data_read_i, data_write_i, data_addr_i,
        input  data_data_i, data_mask_i, ram_din_i,
        output inst_data_o, inst_busy_o, inst_done_o, data_data_o, data_busy_o, data_done_o,
        output ram_addr_o, ram_dout_o, ram_we_o
    );

    // Cache / RAM side
    modport master (
        output inst_read_i, inst_addr_i, data_read_i, data_write_i, data_addr_i,
        output data_data_i, data_mask_i, ram_din_i,
        input  inst_data_o, inst_busy_o, inst_done_o, data_data_o, data_busy_o, data_done_o,
        input  ram_addr_o, ram_dout_o, ram_we_o
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates inst/data cache word requests and serialises each into four byte
// accesses on a synchronous byte RAM with one cycle of read latency.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = AddrWDefault
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);

    state_e            state_q, state_d;
    port_e             port_q, port_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        mask_q, mask_d;
    logic [23:0]       rbuf_q, rbuf_d;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_we_q, ram_we_d;
    logic              guard_q, guard_d;

    logic              inst_req, data_rd_req, data_wr_req;
    logic [1:0]        next_idx;

    // Address bits above the RAM size are deliberately ignored
    logic unused_addr_hi;
    assign unused_addr_hi = ^{bus.inst_addr_i[31:ADDR_W], bus.data_addr_i[31:ADDR_W]};

    // Requests, with the just-served port masked for one IDLE cycle after DONE
    always_comb begin
        inst_req    = bus.inst_read_i  && !(guard_q && port_q == PortInst);
        data_rd_req = bus.data_read_i  && !(guard_q && port_q == PortData);
        data_wr_req = bus.data_write_i && !(guard_q && port_q == PortData);
    end

    // Next-state logic: arbitration, byte sequencing and read-word assembly
    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        mask_d       = mask_q;
        rbuf_d       = rbuf_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        ram_addr_d   = ram_addr_q;
        ram_dout_d   = ram_dout_q;
        ram_we_d     = 1'b0;
        guard_d      = 1'b0;
        next_idx     = cnt_q[1:0] + 2'd1;

        case (state_q)
            StIdle: begin
                if (data_wr_req || data_rd_req) begin
                    port_d     = PortData;
                    base_d     = bus.data_addr_i[ADDR_W-1:0];
                    wdata_d    = bus.data_data_i;
                    mask_d     = bus.data_mask_i;
                    cnt_d      = 3'd0;
                    ram_addr_d = bus.data_addr_i[ADDR_W-1:0];
                    if (data_wr_req) begin
                        state_d    = StWrite;
                        ram_dout_d = get_byte(bus.data_data_i, 2'd0);
                        ram_we_d   = bus.data_mask_i[0];
                    end else begin
                        state_d = StRead;
                    end
                end else if (inst_req) begin
                    port_d     = PortInst;
                    base_d     = bus.inst_addr_i[ADDR_W-1:0];
                    cnt_d      = 3'd0;
                    ram_addr_d = bus.inst_addr_i[ADDR_W-1:0];
                    state_d    = StRead;
                end
            end

            StRead: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < 3'd3) begin
                    ram_addr_d = base_q + ADDR_W'(next_idx);
                end
                // RAM data lags its address by one cycle, so cnt k carries byte k-1
                case (cnt_q)
                    3'd1: rbuf_d[7:0]   = bus.ram_din_i;
                    3'd2: rbuf_d[15:8]  = bus.ram_din_i;
                    3'd3: rbuf_d[23:16] = bus.ram_din_i;
                    ReadLastCnt: begin
                        if (port_q == PortInst) begin
                            inst_rdata_d = {bus.ram_din_i, rbuf_q};
                        end else begin
                            data_rdata_d = {bus.ram_din_i, rbuf_q};
                        end
                        state_d = StDone;
                    end
                    default: ;
                endcase
            end

            StWrite: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q < WriteLastCnt) begin
                    ram_addr_d = base_q + ADDR_W'(next_idx);
                    ram_dout_d = get_byte(wdata_q, next_idx);
                    ram_we_d   = mask_q[next_idx];
                end else begin
                    state_d = StDone;
                end
            end

            StDone: begin
                state_d = StIdle;
                guard_d = 1'b1;
            end

            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= StIdle;
            port_q       <= PortInst;
            cnt_q        <= 3'd0;
            base_q       <= '0;
            wdata_q      <= '0;
            mask_q       <= '0;
            rbuf_q       <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            ram_addr_q   <= '0;
            ram_dout_q   <= '0;
            ram_we_q     <= 1'b0;
            guard_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            mask_q       <= mask_d;
            rbuf_q       <= rbuf_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            ram_addr_q   <= ram_addr_d;
            ram_dout_q   <= ram_dout_d;
            ram_we_q     <= ram_we_d;
            guard_q      <= guard_d;
        end
    end

    // Port outputs
    always_comb begin
        bus.inst_data_o = inst_rdata_q;
        bus.data_data_o = data_rdata_q;
        bus.inst_busy_o = (state_q != StIdle);
        bus.data_busy_o = (state_q != StIdle);
        bus.inst_done_o = (state_q == StDone) && (port_q == PortInst);
        bus.data_done_o = (state_q == StDone) && (port_q == PortData);
        bus.ram_addr_o  = ram_addr_q;
        bus.ram_dout_o  = ram_dout_q;
        bus.ram_we_o    = ram_we_q;
    end

endmodule
